// File: rtl/image_window_buffer.sv
// Image buffer that loads a raster-order pixel stream, then replays it as
// stride-1 KxK convolution windows with valid/ready flow control.
module image_window_buffer #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 5,
    parameter int IMG_H  = 5,
    parameter int K      = 3,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              mem_ok,
    input  logic              start,
    output logic              busy,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              rd_ready,
    output logic              rd_win_last,
    output logic              rd_all_last,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_FULL = 2'd1,
        ST_SCAN = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] ZERO_A   = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ONE_A    = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] IMG_W_A  = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] K_M1     = ADDR_W'(K - 1);
    localparam logic [ADDR_W-1:0] COL_MAX  = ADDR_W'(IMG_W - K);
    localparam logic [ADDR_W-1:0] ROW_MAX  = ADDR_W'(IMG_H - K);
    localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(IMG_W * IMG_H - 1);

    logic [DATA_W-1:0] mem_r [0:(1<<ADDR_W)-1];

    state_t            state_r;
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] row_r;
    logic [ADDR_W-1:0] col_r;
    logic [ADDR_W-1:0] win_i_r;
    logic [ADDR_W-1:0] win_j_r;
    logic              issued_all_r;

    logic              wr_en_s;
    logic              issue_s;
    logic              win_last_s;
    logic              all_last_s;
    logic [ADDR_W-1:0] rd_addr_s;
    logic [ADDR_W-1:0] row_nxt_s;
    logic [ADDR_W-1:0] col_nxt_s;
    logic [ADDR_W-1:0] win_i_nxt_s;
    logic [ADDR_W-1:0] win_j_nxt_s;

    // Window address, beat flags and next scan position (j fastest, then i, c, r).
    always_comb begin
        wr_en_s     = (state_r == ST_LOAD) && wr_valid && !clear && !rst;
        rd_addr_s   = (row_r + win_i_r) * IMG_W_A + col_r + win_j_r;
        win_last_s  = (win_i_r == K_M1) && (win_j_r == K_M1);
        all_last_s  = win_last_s && (row_r == ROW_MAX) && (col_r == COL_MAX);
        // The output register may be refilled when empty or being drained this cycle.
        issue_s     = (state_r == ST_SCAN) && !issued_all_r && (!rd_valid || rd_ready);
        row_nxt_s   = row_r;
        col_nxt_s   = col_r;
        win_i_nxt_s = win_i_r;
        win_j_nxt_s = win_j_r;
        if (win_j_r != K_M1) begin
            win_j_nxt_s = win_j_r + ONE_A;
        end else begin
            win_j_nxt_s = ZERO_A;
            if (win_i_r != K_M1) begin
                win_i_nxt_s = win_i_r + ONE_A;
            end else begin
                win_i_nxt_s = ZERO_A;
                if (col_r != COL_MAX) begin
                    col_nxt_s = col_r + ONE_A;
                end else begin
                    col_nxt_s = ZERO_A;
                    row_nxt_s = row_r + ONE_A;
                end
            end
        end
    end

    // Pixel storage, written only while loading; contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Control FSM with registered outputs and the registered memory read port.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_r      <= ST_LOAD;
            wr_ptr_r     <= ZERO_A;
            row_r        <= ZERO_A;
            col_r        <= ZERO_A;
            win_i_r      <= ZERO_A;
            win_j_r      <= ZERO_A;
            issued_all_r <= 1'b0;
            wr_ready     <= 1'b1;
            mem_ok       <= 1'b0;
            busy         <= 1'b0;
            rd_valid     <= 1'b0;
            rd_data      <= {DATA_W{1'b0}};
            rd_win_last  <= 1'b0;
            rd_all_last  <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_LOAD: begin
                    if (wr_valid) begin
                        if (wr_ptr_r == PIX_LAST) begin
                            state_r  <= ST_FULL;
                            wr_ptr_r <= ZERO_A;
                            wr_ready <= 1'b0;
                            mem_ok   <= 1'b1;
                        end else begin
                            wr_ptr_r <= wr_ptr_r + ONE_A;
                        end
                    end
                end
                ST_FULL: begin
                    if (start) begin
                        state_r      <= ST_SCAN;
                        busy         <= 1'b1;
                        row_r        <= ZERO_A;
                        col_r        <= ZERO_A;
                        win_i_r      <= ZERO_A;
                        win_j_r      <= ZERO_A;
                        issued_all_r <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (rd_valid && rd_ready && rd_all_last) begin
                        state_r     <= ST_FULL;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        rd_valid    <= 1'b0;
                        rd_win_last <= 1'b0;
                        rd_all_last <= 1'b0;
                    end else if (issue_s) begin
                        rd_valid     <= 1'b1;
                        rd_data      <= mem_r[rd_addr_s];
                        rd_win_last  <= win_last_s;
                        rd_all_last  <= all_last_s;
                        issued_all_r <= all_last_s;
                        row_r        <= row_nxt_s;
                        col_r        <= col_nxt_s;
                        win_i_r      <= win_i_nxt_s;
                        win_j_r      <= win_j_nxt_s;
                    end else if (rd_valid && rd_ready) begin
                        rd_valid    <= 1'b0;
                        rd_win_last <= 1'b0;
                        rd_all_last <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_image_window_buffer.sv
// Directed bench for image_window_buffer: a 5x5/K=3 instance plus 4x3 instances
// with K=3 and K=1 sharing the same input stimulus.
module tb_image_window_buffer;

    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, clear, wr_valid, start, rd_ready;
    logic [DW-1:0] wr_data;

    logic          m_wr_ready, m_mem_ok, m_busy, m_rd_valid, m_wl, m_al, m_done;
    logic [DW-1:0] m_rd_data;
    logic          e_wr_ready, e_mem_ok, e_busy, e_rd_valid, e_wl, e_al, e_done;
    logic [DW-1:0] e_rd_data;
    logic          k_wr_ready, k_mem_ok, k_busy, k_rd_valid, k_wl, k_al, k_done;
    logic [DW-1:0] k_rd_data;

    image_window_buffer #(.DATA_W(DW), .IMG_W(5), .IMG_H(5), .K(3), .ADDR_W(5)) dut_m (
        .clk(clk), .rst(rst), .clear(clear), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(m_wr_ready), .mem_ok(m_mem_ok), .start(start), .busy(m_busy),
        .rd_valid(m_rd_valid), .rd_data(m_rd_data), .rd_ready(rd_ready),
        .rd_win_last(m_wl), .rd_all_last(m_al), .done(m_done));

    image_window_buffer #(.DATA_W(DW), .IMG_W(4), .IMG_H(3), .K(3), .ADDR_W(4)) dut_e (
        .clk(clk), .rst(rst), .clear(clear), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(e_wr_ready), .mem_ok(e_mem_ok), .start(start), .busy(e_busy),
        .rd_valid(e_rd_valid), .rd_data(e_rd_data), .rd_ready(rd_ready),
        .rd_win_last(e_wl), .rd_all_last(e_al), .done(e_done));

    image_window_buffer #(.DATA_W(DW), .IMG_W(4), .IMG_H(3), .K(1), .ADDR_W(4)) dut_k (
        .clk(clk), .rst(rst), .clear(clear), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(k_wr_ready), .mem_ok(k_mem_ok), .start(start), .busy(k_busy),
        .rd_valid(k_rd_valid), .rd_data(k_rd_data), .rd_ready(rd_ready),
        .rd_win_last(k_wl), .rd_all_last(k_al), .done(k_done));

    int checks = 0;
    int passes = 0;
    int mb [0:127];
    int eb [0:127];
    int kb [0:127];
    int nm, ne, nk;
    int m_done_cnt, e_done_cnt, k_done_cnt, m_done_cyc, m_first_cyc, stall_bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int code(input logic [DW-1:0] d, input logic wl, input logic al);
        return int'({14'd0, al, wl, d});
    endfunction

    // Expected beat: pixel (r+i)*W + c+j plus flags, derived from the beat index.
    function automatic int exp_code(input int w, input int h, input int k, input int base, input int idx);
        int nc, kk, total, win, p, v, wl, al;
        nc    = w - k + 1;
        kk    = k * k;
        total = (h - k + 1) * nc * kk;
        win   = idx / kk;
        p     = idx % kk;
        v     = base + ((win / nc) + (p / k)) * w + (win % nc) + (p % k);
        wl    = (p == kk - 1) ? 1 : 0;
        al    = (idx == total - 1) ? 1 : 0;
        return (al << 17) | (wl << 16) | v;
    endfunction

    task automatic cmp_seq(input int sel, input int w, input int h, input int k,
                           input int base, input string tag);
        int total, n, bad, got;
        total = (h - k + 1) * (w - k + 1) * k * k;
        n     = (sel == 0) ? nm : ((sel == 1) ? ne : nk);
        chk({tag, "_count"}, n, total);
        bad = 0;
        for (int idx = 0; idx < total && idx < n; idx++) begin
            got = (sel == 0) ? mb[idx] : ((sel == 1) ? eb[idx] : kb[idx]);
            if (got != exp_code(w, h, k, base, idx)) bad++;
        end
        chk({tag, "_bad_beats"}, bad, 0);
    endtask

    task automatic load(input int base, input int count);
        for (int i = 0; i < count; i++) begin
            wr_valid = 1'b1;
            wr_data  = 16'(base + i);
            tick();
        end
        wr_valid = 1'b0;
    endtask

    // Pulse start, then accept beats from all three instances until the main one finishes.
    task automatic scan(input bit bp, input int stop_at);
        int held;
        bit stalled;
        nm = 0; ne = 0; nk = 0;
        m_done_cnt = 0; e_done_cnt = 0; k_done_cnt = 0;
        m_done_cyc = -1; m_first_cyc = -1; stall_bad = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", m_busy, 1'b1);
        chk("no_valid_at_start", m_rd_valid, 1'b0);
        for (int cyc = 0; cyc < 2000; cyc++) begin
            rd_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_rd_valid && m_first_cyc < 0) m_first_cyc = cyc;
            if (m_rd_valid && rd_ready && nm < 128) begin mb[nm] = code(m_rd_data, m_wl, m_al); nm++; end
            if (e_rd_valid && rd_ready && ne < 128) begin eb[ne] = code(e_rd_data, e_wl, e_al); ne++; end
            if (k_rd_valid && rd_ready && nk < 128) begin kb[nk] = code(k_rd_data, k_wl, k_al); nk++; end
            held    = code(m_rd_data, m_wl, m_al);
            stalled = m_rd_valid && !rd_ready;
            tick();
            if (stalled && (!m_rd_valid || code(m_rd_data, m_wl, m_al) != held)) stall_bad++;
            if (m_done) begin
                m_done_cnt++;
                if (m_done_cyc < 0) m_done_cyc = cyc + 1;
            end
            if (e_done) e_done_cnt++;
            if (k_done) k_done_cnt++;
            if (stop_at > 0 && nm == stop_at) break;
            if (m_done_cyc >= 0 && cyc >= m_done_cyc + 2) break;
        end
        rd_ready = 1'b1;
    endtask

    initial begin
        int fw [0:8]  = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
        int lw [0:8]  = '{12, 13, 14, 17, 18, 19, 22, 23, 24};
        int ew [0:17] = '{0, 1, 2, 4, 5, 6, 8, 9, 10, 1, 2, 3, 5, 6, 7, 9, 10, 11};
        int wl_cnt;

        rst = 1'b1; clear = 1'b0; wr_valid = 1'b0; start = 1'b0; rd_ready = 1'b1;
        wr_data = 16'd0;
        tick();
        chk("rst_wr_ready", m_wr_ready, 1'b1);
        chk("rst_mem_ok", m_mem_ok, 1'b0);
        chk("rst_busy", m_busy, 1'b0);
        chk("rst_rd_valid", m_rd_valid, 1'b0);
        chk("rst_rd_data", m_rd_data, 16'd0);
        chk("rst_flags", {m_wl, m_al, m_done}, 3'd0);
        tick();
        rst = 1'b0;

        // Load 0..24; the 4x3 instances fill after 12 pixels and ignore the rest.
        for (int i = 0; i < 25; i++) begin
            wr_valid = 1'b1;
            wr_data  = 16'(i);
            tick();
            if (i == 10) chk("e_mem_ok_early", e_mem_ok, 1'b0);
            if (i == 11) chk("e_mem_ok_full", e_mem_ok, 1'b1);
            if (i == 23) chk("mem_ok_before_last", m_mem_ok, 1'b0);
            if (i == 24) chk("mem_ok_after_last", m_mem_ok, 1'b1);
        end
        wr_data = 16'h7777;
        tick();
        wr_valid = 1'b0;
        chk("wr_ready_when_full", m_wr_ready, 1'b0);
        chk("mem_ok_held", m_mem_ok, 1'b1);

        // Full-rate scan.
        scan(1'b0, 0);
        chk("first_valid_latency", m_first_cyc, 1);
        chk("done_cycle_no_bubbles", m_done_cyc, 82);
        chk("done_pulses", m_done_cnt, 1);
        chk("busy_after_done", m_busy, 1'b0);
        cmp_seq(0, 5, 5, 3, 0, "scan1");
        for (int i = 0; i < 9; i++) begin
            chk("first_window", mb[i] & 32'hFFFF, fw[i]);
            chk("last_window", mb[72 + i] & 32'hFFFF, lw[i]);
        end
        chk("first_win_last", (mb[8] >> 16) & 3, 1);
        chk("all_last_beat", (mb[80] >> 16) & 3, 3);
        cmp_seq(1, 4, 3, 3, 0, "edge_k3");
        for (int i = 0; i < 18; i++) chk("edge_k3_window", eb[i] & 32'hFFFF, ew[i]);
        chk("edge_k3_done", e_done_cnt, 1);
        cmp_seq(2, 4, 3, 1, 0, "edge_k1");
        chk("edge_k1_done", k_done_cnt, 1);

        // Rescan under random backpressure.
        scan(1'b1, 0);
        cmp_seq(0, 5, 5, 3, 0, "scan_bp");
        chk("stall_stability", stall_bad, 0);
        chk("done_pulses_bp", m_done_cnt, 1);
        wl_cnt = 0;
        for (int i = 0; i < nm && i < 128; i++) if (((mb[i] >> 16) & 1) == 1) wl_cnt++;
        chk("win_last_pulses", wl_cnt, 9);

        // Clear in the middle of a scan.
        scan(1'b1, 20);
        chk("beats_before_clear", nm, 20);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear_rd_valid", m_rd_valid, 1'b0);
        chk("clear_mem_ok", m_mem_ok, 1'b0);
        chk("clear_busy", m_busy, 1'b0);
        chk("clear_wr_ready", m_wr_ready, 1'b1);

        // Reload with new data and rescan.
        load(100, 25);
        chk("reload_mem_ok", m_mem_ok, 1'b1);
        scan(1'b0, 0);
        chk("reload_px0", mb[0] & 32'hFFFF, 100);
        chk("reload_px1", mb[1] & 32'hFFFF, 101);
        chk("reload_px2", mb[2] & 32'hFFFF, 102);
        chk("reload_px3", mb[3] & 32'hFFFF, 105);
        cmp_seq(0, 5, 5, 3, 100, "reload");
        cmp_seq(1, 4, 3, 3, 100, "reload_edge_k3");

        // Reset mid-load, start ignored in LOAD, then a clean full load.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        load(300, 10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_load_mem_ok", m_mem_ok, 1'b0);
        chk("rst_load_wr_ready", m_wr_ready, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_in_load_busy", m_busy, 1'b0);
        tick();
        chk("start_in_load_busy2", m_busy, 1'b0);
        chk("start_in_load_valid", m_rd_valid, 1'b0);
        for (int i = 0; i < 25; i++) begin
            wr_valid = 1'b1;
            wr_data  = 16'(200 + i);
            tick();
            if (i == 14) chk("ptr_cleared_by_rst", m_mem_ok, 1'b0);
            if (i == 24) chk("post_rst_mem_ok", m_mem_ok, 1'b1);
        end
        wr_valid = 1'b0;
        scan(1'b0, 0);
        cmp_seq(0, 5, 5, 3, 200, "post_rst");
        chk("post_rst_done", m_done_cnt, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
